// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache controller: line states, bus operations, FSM states.
package msi_pkg;

  localparam logic [1:0] LS_INVALID   = 2'b00;
  localparam logic [1:0] LS_EXCLUSIVE = 2'b01;
  localparam logic [1:0] LS_SHARED    = 2'b10;

  localparam logic [1:0] OP_READ_MISS  = 2'b00;
  localparam logic [1:0] OP_WRITE_MISS = 2'b01;
  localparam logic [1:0] OP_INVALIDATE = 2'b10;
  localparam logic [1:0] OP_WRITE_BACK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WB   = 2'b01,
    ST_REQ  = 2'b10,
    ST_ACK  = 2'b11
  } fsm_state_t;

endpackage

// File: rtl/msi_line_store.sv
// Tag/state arrays of the direct-mapped cache: two combinational read ports,
// a snoop write port and an own write port that wins on the same index.
module msi_line_store
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] cpu_idx,
  output logic [TAG_W-1:0] cpu_tag,
  output logic [1:0]       cpu_state,
  input  logic [IDX_W-1:0] snp_idx,
  output logic [TAG_W-1:0] snp_tag,
  output logic [1:0]       snp_state,
  input  logic             snp_we,
  input  logic [IDX_W-1:0] snp_widx,
  input  logic [1:0]       snp_wstate,
  input  logic             own_we,
  input  logic [IDX_W-1:0] own_widx,
  input  logic [TAG_W-1:0] own_wtag,
  input  logic [1:0]       own_wstate
);

  logic [TAG_W-1:0] tags   [NUM_LINES];
  logic [1:0]       states [NUM_LINES];

  assign cpu_tag   = tags[cpu_idx];
  assign cpu_state = states[cpu_idx];
  assign snp_tag   = tags[snp_idx];
  assign snp_state = states[snp_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tags[i]   <= '0;
        states[i] <= LS_INVALID;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        // Own completion overrides a snoop update landing on the same line.
        if (own_we && own_widx == IDX_W'(i)) begin
          tags[i]   <= own_wtag;
          states[i] <= own_wstate;
        end else if (snp_we && snp_widx == IDX_W'(i)) begin
          states[i] <= snp_wstate;
        end
      end
    end
  end

endmodule

// File: rtl/msi_cpu_controller.sv
// CPU-side MSI controller: turns CPU requests into bus operations with a req/gnt
// handshake and applies snooped bus traffic to the local line states.
module msi_cpu_controller
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [1:0]        cpu_line_state,
  output logic              bus_req,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_gnt,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  fsm_state_t state_q, state_d;

  logic [1:0]        miss_op_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [1:0]        bus_op_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              flush_q;

  logic [IDX_W-1:0] cpu_idx, snp_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag_in, snp_tag_in;
  logic [TAG_W-1:0] line_tag, snp_line_tag;
  logic [1:0]       line_state, snp_line_state;

  logic             hit, victim_dirty;
  logic [1:0]       req_op;

  logic             snp_match, snp_we, flush_d, kill_same, wb_snooped;
  logic [1:0]       snp_wstate;

  logic             own_we;
  logic [TAG_W-1:0] own_wtag;
  logic [1:0]       own_wstate;

  assign cpu_idx    = cpu_addr[IDX_W-1:0];
  assign cpu_tag_in = cpu_addr[ADDR_W-1:IDX_W];
  assign snp_idx    = snoop_addr[IDX_W-1:0];
  assign snp_tag_in = snoop_addr[ADDR_W-1:IDX_W];
  assign req_idx    = req_addr_q[IDX_W-1:0];

  msi_line_store #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_store (
    .clock     (clock),
    .reset     (reset),
    .cpu_idx   (cpu_idx),
    .cpu_tag   (line_tag),
    .cpu_state (line_state),
    .snp_idx   (snp_idx),
    .snp_tag   (snp_line_tag),
    .snp_state (snp_line_state),
    .snp_we    (snp_we),
    .snp_widx  (snp_idx),
    .snp_wstate(snp_wstate),
    .own_we    (own_we),
    .own_widx  (req_idx),
    .own_wtag  (own_wtag),
    .own_wstate(own_wstate)
  );

  assign cpu_line_state = (line_tag == cpu_tag_in) ? line_state : LS_INVALID;
  assign hit            = (line_tag == cpu_tag_in) && (line_state != LS_INVALID);
  assign victim_dirty   = (line_state == LS_EXCLUSIVE) && (line_tag != cpu_tag_in);
  assign req_op         = !cpu_we ? OP_READ_MISS : (hit ? OP_INVALIDATE : OP_WRITE_MISS);

  // Snoop decode, active in every FSM state.
  assign snp_match = snoop_valid && (snp_line_tag == snp_tag_in) &&
                     (snp_line_state != LS_INVALID);

  always_comb begin
    snp_we     = 1'b0;
    snp_wstate = snp_line_state;
    flush_d    = 1'b0;
    if (snp_match) begin
      case (snoop_op)
        OP_READ_MISS: if (snp_line_state == LS_EXCLUSIVE) begin
          snp_we = 1'b1; snp_wstate = LS_SHARED; flush_d = 1'b1;
        end
        OP_WRITE_MISS: begin
          snp_we     = 1'b1;
          snp_wstate = LS_INVALID;
          flush_d    = (snp_line_state == LS_EXCLUSIVE);
        end
        OP_INVALIDATE: if (snp_line_state == LS_SHARED) begin
          snp_we = 1'b1; snp_wstate = LS_INVALID;
        end
        default: ;
      endcase
    end
  end

  assign kill_same  = snp_we && (snp_wstate == LS_INVALID) && (snp_idx == req_idx);
  // A snooped miss on the dirty victim already flushed it, so our write-back is moot.
  assign wb_snooped = flush_d && (snp_idx == req_idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cpu_req) begin
        if (hit && (!cpu_we || line_state == LS_EXCLUSIVE)) state_d = ST_ACK;
        else if (victim_dirty)                              state_d = ST_WB;
        else                                                state_d = ST_REQ;
      end
      ST_WB:   if (bus_gnt || wb_snooped) state_d = ST_REQ;
      ST_REQ:  if (bus_gnt) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req     = (state_q == ST_WB) || (state_q == ST_REQ);
    bus_op      = bus_op_q;
    bus_addr    = bus_addr_q;
    cpu_ack     = (state_q == ST_ACK);
    snoop_flush = flush_q;
    own_we      = 1'b0;
    own_wtag    = req_addr_q[ADDR_W-1:IDX_W];
    own_wstate  = LS_INVALID;
    if (state_q == ST_WB && bus_gnt) begin
      own_we   = 1'b1;
      own_wtag = bus_addr_q[ADDR_W-1:IDX_W];
    end else if (state_q == ST_REQ && bus_gnt) begin
      own_we     = 1'b1;
      own_wstate = (bus_op_q == OP_READ_MISS) ? LS_SHARED : LS_EXCLUSIVE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_op_q  <= OP_READ_MISS;
      req_addr_q <= '0;
      bus_op_q   <= OP_READ_MISS;
      bus_addr_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      flush_q <= flush_d;
      if (state_q == ST_IDLE && cpu_req && state_d != ST_ACK) begin
        req_addr_q <= cpu_addr;
        miss_op_q  <= req_op;
        if (victim_dirty) begin
          bus_op_q   <= OP_WRITE_BACK;
          bus_addr_q <= {line_tag, cpu_idx};
        end else begin
          bus_op_q   <= req_op;
          bus_addr_q <= cpu_addr;
        end
      end else if (state_q == ST_WB && (bus_gnt || wb_snooped)) begin
        bus_op_q   <= miss_op_q;
        bus_addr_q <= req_addr_q;
      end else if (state_q == ST_REQ && !bus_gnt &&
                   bus_op_q == OP_INVALIDATE && kill_same) begin
        // Our shared copy was killed before the upgrade was granted.
        bus_op_q <= OP_WRITE_MISS;
      end
    end
  end

endmodule

// File: doc/msi_cpu_controller.md
Name: msi_cpu_controller

Overview:
- CPU-side MSI coherence controller for a small direct-mapped cache.
- Sits directly upstream of the bus-side snoop state machine.
- Turns CPU read/write requests into bus operations (read_miss, write_miss, invalidate, write_back), using a req/gnt handshake with the bus.
- Applies incoming snooped bus operations to its own line states, and raises a flush pulse when a modified line must be written back.

Parameters:
- NUM_LINES, 4, number of cache lines (power of 2, >=2); IDX_W = log2(NUM_LINES).
- ADDR_W, 8, block address width; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU request valid; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  block address; stable while cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_line_state  out  2  combinational state of the line addressed by cpu_addr (I if tag mismatch).
- bus_req  out  1  bus operation pending.
- bus_op  out  2  00 read_miss, 01 write_miss, 10 invalidate, 11 write_back.
- bus_addr  out  ADDR_W  address of the pending operation.
- bus_gnt  in  1  bus accepts the pending operation on this edge.
- snoop_valid  in  1  another cache's bus operation is visible.
- snoop_op  in  2  same encoding as bus_op.
- snoop_addr  in  ADDR_W  snooped address.
- snoop_flush  out  1  one-cycle pulse: this cache supplies or writes back a modified block.

Behaviour:
- Line states: invalid 00, exclusive/modified 01, shared 10.
- Reset, asynchronous:
  - all lines invalid, tags 0.
  - FSM IDLE.
  - cpu_ack, bus_req, snoop_flush all 0; bus_op 00; bus_addr 0.
  - Asserting reset mid-operation drops bus_req immediately and discards the pending request.
- FSM states: IDLE, WB, REQ, ACK.
- IDLE, cpu_req sampled at edge N. Hit = tag match and state != I.
  - read hit (S/E), or write hit on E: go to ACK; cpu_ack=1 in cycle N+1; no bus activity.
  - write hit on S: go to REQ; op=invalidate.
  - read miss: op=read_miss.
  - write miss: op=write_miss.
  - Victim with state E and a different tag: go to WB first (op=write_back, bus_addr={victim tag, index}). Otherwise go to REQ.
- WB/REQ:
  - bus_req=1 and bus_op/bus_addr are held stable until the edge where bus_gnt=1.
  - Grant in WB: victim line becomes I; go to REQ with the miss op.
  - Grant in REQ:
    - read_miss: line becomes S, tag updated.
    - write_miss/invalidate: line becomes E, tag updated.
    - Go to ACK; bus_req=0.
- ACK: cpu_ack=1 for exactly one cycle, then IDLE. A held cpu_req is not resampled until IDLE.
- bus_gnt while bus_req=0 is ignored.
- Snoop: evaluated every cycle in every FSM state. Acts only when snoop_valid, tag match and state != I.
  - read_miss on E: E to S, snoop_flush=1 next cycle.
  - write_miss on E: E to I, snoop_flush=1.
  - write_miss on S: S to I.
  - invalidate on S: S to I.
  - write_back: no effect.
  - All other combinations: no change.
- Race, in REQ with op=invalidate: if a snoop kills the same line, bus_op becomes write_miss from the next cycle; bus_req stays high.
- Race, in WB: a snoop read_miss/write_miss on the victim line before grant completes the victim's write-back via snoop_flush. The FSM skips to REQ and does not issue a write_back.
- Simultaneous bus_gnt and a matching snoop on the same edge: the snoop update is applied first and the own-completion update overrides it (own op wins).
- No arithmetic beyond index/tag slicing; no wrap-around concerns.

Decomposition:
- msi_pkg:
  - line-state localparams (LS_INVALID, LS_EXCLUSIVE, LS_SHARED).
  - bus-op localparams (OP_READ_MISS, OP_WRITE_MISS, OP_INVALIDATE, OP_WRITE_BACK).
  - FSM state encodings.
- Sub-module msi_line_store holds the tag and state arrays:
  - two combinational read ports (CPU index, snoop index).
  - one snoop write port and one own write port, with own-write priority on the same index.
  - asynchronous clear on reset.
- msi_cpu_controller holds the FSM, the bus handshake and the snoop decode.

Test Plan (NUM_LINES=4, ADDR_W=8):
1. Cold read:
   - Stimulus: after reset, read 0x14; bus_gnt 2 cycles after bus_req.
   - Required: bus_op=00, bus_addr=0x14 held until gnt; cpu_ack one cycle after gnt; cpu_line_state=10.
2. Upgrade then hit:
   - Stimulus: write 0x14 with the line in S; then write 0x14 again.
   - Required: first write gives bus_op=10 and line E after gnt; second write gives cpu_ack in cycle N+1 with bus_req never high.
3. Eviction:
   - Stimulus: line 0 is E with tag 0x05 (addr 0x14); read 0x24.
   - Required: bus_op=11 addr 0x14, grant; then bus_op=00 addr 0x24, grant; line 0 ends S with tag 0x09.
4. Snoop:
   - Stimulus: line at 0x14 in E; snoop read_miss 0x14; then snoop invalidate 0x14; then snoop write_miss 0x24.
   - Required: read_miss gives snoop_flush pulse and state S; invalidate gives state I; write_miss 0x24 gives no change.
5. Race:
   - Stimulus: invalidate for 0x14 pending with no gnt; snoop write_miss 0x14.
   - Required: bus_op=01 next cycle, bus_req stays high; gnt gives line E and cpu_ack.
6. Reset mid-operation:
   - Stimulus: assert reset between clock edges while bus_req=1.
   - Required: bus_req=0 before the next edge; all lines I; after release, read 0x14 misses again.
